multi_lifo: RTL and testbench

Parametrised multi-channel LIFO: CHANNELS independent stacks, each 2**AWIDTH words of DWIDTH bits, sharing one simple dual-port RAM. One push and one pop are accepted per cycle, each with its own channel index. Per-channel flush is supported. The block replaces single-channel `lifo` instances where several producers/consumers need stacks, and exposes per-channel fill level and flags as packed vectors.

---
 rtl/multi_lifo_pkg.sv | 18 +
 rtl/multi_lifo_ram.sv | 33 +++
 rtl/multi_lifo.sv | 137 +++++++++++++
 tb/tb_multi_lifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/multi_lifo_pkg.sv
// Shared definitions for the multi-channel LIFO.
// Contents:
//   cw_of()      - channel-index width; at least one bit even for a single channel
//   lifo_flags_t - per-channel status flags, used when viewing one channel's state
package multi_lifo_pkg;

    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic almost_empty;
        logic almost_full;
        logic full;
    } lifo_flags_t;

endpackage

// File: rtl/multi_lifo_ram.sv
// Simple dual-port RAM that backs all stacks of multi_lifo.
// Ports:
//   clk   - clock
//   we    - write enable; waddr/wdata - write address and data
//   re    - read enable; raddr - read address
//   q     - registered read data, updated only when re is high (holds otherwise)
// The array has no reset; its contents are only meaningful below each stack's level.
module multi_lifo_ram #(
    parameter int DWIDTH = 16,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DWIDTH-1:0] q
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            q <= mem[raddr];
        end
    end

endmodule

// File: rtl/multi_lifo.sv
// Multi-channel LIFO: CHANNELS independent stacks sharing one dual-port RAM.
// Ports:
//   clk_i, srst_i             - clock, synchronous active-high reset
//   wrreq_i, wr_ch_i, data_i  - push request, channel, data
//   rdreq_i, rd_ch_i          - pop request, channel
//   flush_i                   - per-channel flush (empties the stack)
//   q_o, q_valid_o, q_ch_o    - popped data one cycle after the pop, its valid and channel
//   usedw_o                   - packed per-channel fill levels, AWIDTH+1 bits each
//   empty_o, almost_empty_o, almost_full_o, full_o - per-channel flags
module multi_lifo
    import multi_lifo_pkg::*;
#(
    parameter int  CHANNELS     = 4,
    parameter int  DWIDTH       = 16,
    parameter int  AWIDTH       = 8,
    parameter int  ALMOST_FULL  = 2,
    parameter int  ALMOST_EMPTY = 2,
    localparam int CW           = cw_of(CHANNELS)
) (
    input  logic                           clk_i,
    input  logic                           srst_i,
    input  logic                           wrreq_i,
    input  logic [CW-1:0]                  wr_ch_i,
    input  logic [DWIDTH-1:0]              data_i,
    input  logic                           rdreq_i,
    input  logic [CW-1:0]                  rd_ch_i,
    input  logic [CHANNELS-1:0]            flush_i,
    output logic [DWIDTH-1:0]              q_o,
    output logic                           q_valid_o,
    output logic [CW-1:0]                  q_ch_o,
    output logic [CHANNELS*(AWIDTH+1)-1:0] usedw_o,
    output logic [CHANNELS-1:0]            empty_o,
    output logic [CHANNELS-1:0]            almost_empty_o,
    output logic [CHANNELS-1:0]            almost_full_o,
    output logic [CHANNELS-1:0]            full_o
);

    localparam int unsigned NCH  = CHANNELS;
    localparam int unsigned NPAD = 2 ** CW;
    localparam int unsigned LW   = AWIDTH + 1;
    localparam logic [AWIDTH:0] DEPTH   = LW'(2 ** AWIDTH);
    localparam logic [AWIDTH:0] AF_LVL  = LW'(2 ** AWIDTH - ALMOST_FULL);
    localparam logic [AWIDTH:0] AE_LVL  = LW'(ALMOST_EMPTY);

    // Level array is padded to every encodable channel index so that indexing
    // by wr_ch_i/rd_ch_i never leaves the array; padded entries stay at zero.
    logic [AWIDTH:0]   usedw     [NPAD];
    logic [AWIDTH:0]   usedw_nxt [NPAD];
    logic [NPAD-1:0]   ch_ok;
    logic [NPAD-1:0]   flush_pad;
    logic [NPAD-1:0]   empty_pad;
    logic [NPAD-1:0]   full_pad;

    logic              wr_ok, rd_ok, bypass, push, pop;
    logic [AWIDTH-1:0] rd_off;
    logic [DWIDTH-1:0] ram_q;
    logic [DWIDTH-1:0] byp_data;
    logic              sel_byp;

    always_comb begin
        flush_pad = NPAD'(flush_i);
        for (int unsigned c = 0; c < NPAD; c++) begin
            ch_ok[c]     = (c < NCH);
            empty_pad[c] = (usedw[c] == '0);
            full_pad[c]  = (usedw[c] == DEPTH);
        end

        // Flush on a channel cancels any request aimed at it; a same-channel
        // push+pop becomes a bypass and never touches the RAM or the level.
        wr_ok  = wrreq_i && ch_ok[wr_ch_i] && !flush_pad[wr_ch_i];
        rd_ok  = rdreq_i && ch_ok[rd_ch_i] && !flush_pad[rd_ch_i];
        bypass = wr_ok && rd_ok && (wr_ch_i == rd_ch_i);
        push   = wr_ok && !bypass && !full_pad[wr_ch_i];
        pop    = rd_ok && !bypass && !empty_pad[rd_ch_i];

        rd_off = usedw[rd_ch_i][AWIDTH-1:0] - AWIDTH'(1);

        for (int unsigned c = 0; c < NPAD; c++) begin
            usedw_nxt[c] = usedw[c];
            if (flush_pad[c]) begin
                usedw_nxt[c] = '0;
            end else begin
                if (push && (wr_ch_i == CW'(c))) usedw_nxt[c] = usedw[c] + 1'b1;
                if (pop  && (rd_ch_i == CW'(c))) usedw_nxt[c] = usedw[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int unsigned c = 0; c < NPAD; c++) usedw[c] <= '0;
            q_valid_o <= 1'b0;
            q_ch_o    <= '0;
            sel_byp   <= 1'b1;
            byp_data  <= '0;
        end else begin
            for (int unsigned c = 0; c < NPAD; c++) usedw[c] <= usedw_nxt[c];
            q_valid_o <= pop || bypass;
            if (pop || bypass) begin
                q_ch_o  <= rd_ch_i;
                sel_byp <= bypass;
            end
            if (bypass) begin
                byp_data <= data_i;
            end
        end
    end

    // Both sources only change on an accepted pop, so q_o holds between pops.
    assign q_o = sel_byp ? byp_data : ram_q;

    always_comb begin
        usedw_o = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            usedw_o[c*LW +: LW] = usedw[c];
            empty_o[c]          = (usedw[c] == '0);
            full_o[c]           = (usedw[c] == DEPTH);
            almost_empty_o[c]   = (usedw[c] <= AE_LVL);
            almost_full_o[c]    = (usedw[c] >= AF_LVL);
        end
    end

    multi_lifo_ram #(
        .DWIDTH (DWIDTH),
        .ADDR_W (CW + AWIDTH),
        .DEPTH  (CHANNELS * (2 ** AWIDTH))
    ) u_ram (
        .clk   (clk_i),
        .we    (push),
        .waddr ({wr_ch_i, usedw[wr_ch_i][AWIDTH-1:0]}),
        .wdata (data_i),
        .re    (pop),
        .raddr ({rd_ch_i, rd_off}),
        .q     (ram_q)
    );

endmodule

// File: tb/tb_multi_lifo.sv
// Directed testbench for multi_lifo with default parameters.
module tb_multi_lifo;
    import multi_lifo_pkg::*;

    localparam int CH = 4;
    localparam int CW = 2;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LW = AW + 1;

    logic              clk = 1'b0;
    logic              srst = 1'b0;
    logic              wrreq = 1'b0;
    logic [CW-1:0]     wr_ch = '0;
    logic [DW-1:0]     data = '0;
    logic              rdreq = 1'b0;
    logic [CW-1:0]     rd_ch = '0;
    logic [CH-1:0]     flush = '0;
    logic [DW-1:0]     q;
    logic              q_valid;
    logic [CW-1:0]     q_ch;
    logic [CH*LW-1:0]  usedw;
    logic [CH-1:0]     empty, almost_empty, almost_full, full;

    int checks = 0;
    int failures = 0;

    multi_lifo #(
        .CHANNELS     (CH),
        .DWIDTH       (DW),
        .AWIDTH       (AW),
        .ALMOST_FULL  (2),
        .ALMOST_EMPTY (2)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .wrreq_i        (wrreq),
        .wr_ch_i        (wr_ch),
        .data_i         (data),
        .rdreq_i        (rdreq),
        .rd_ch_i        (rd_ch),
        .flush_i        (flush),
        .q_o            (q),
        .q_valid_o      (q_valid),
        .q_ch_o         (q_ch),
        .usedw_o        (usedw),
        .empty_o        (empty),
        .almost_empty_o (almost_empty),
        .almost_full_o  (almost_full),
        .full_o         (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] lvl(input int c);
        return usedw[c*LW +: LW];
    endfunction

    function automatic lifo_flags_t flags_of(input int c);
        lifo_flags_t f;
        f.empty        = empty[c];
        f.almost_empty = almost_empty[c];
        f.almost_full  = almost_full[c];
        f.full         = full[c];
        return f;
    endfunction

    task automatic push(input logic [CW-1:0] ch, input logic [DW-1:0] d);
        wrreq = 1'b1; wr_ch = ch; data = d;
        step();
        wrreq = 1'b0;
    endtask

    initial begin
        // Reset
        srst = 1'b1;
        step(); step();
        srst = 1'b0;
        check("rst_usedw", usedw, '0);
        check("rst_q", q, 16'h0);
        check("rst_qvalid", q_valid, 1'b0);
        check("rst_qch", q_ch, 2'd0);
        for (int c = 0; c < CH; c++)
            check($sformatf("rst_flags_ch%0d", c), flags_of(c), 4'b1100);

        // Push 1..5 on ch2, pop five back in reverse order
        for (int i = 1; i <= 5; i++) push(2'd2, DW'(i));
        check("ch2_lvl5", lvl(2), 9'd5);
        check("ch2_ae_at5", almost_empty[2], 1'b0);
        rdreq = 1'b1; rd_ch = 2'd2;
        for (int i = 1; i <= 5; i++) begin
            step();
            check($sformatf("pop_q_%0d", i), q, 16'(6 - i));
            check($sformatf("pop_v_%0d", i), q_valid, 1'b1);
            check($sformatf("pop_ch_%0d", i), q_ch, 2'd2);
        end
        rdreq = 1'b0;
        check("ch2_lvl0", lvl(2), 9'd0);
        check("ch2_empty", empty[2], 1'b1);
        step();
        check("idle_qvalid", q_valid, 1'b0);
        check("idle_q_hold", q, 16'h0001);

        // Pop an empty channel
        rdreq = 1'b1; rd_ch = 2'd3;
        step();
        rdreq = 1'b0;
        check("empty_pop_v", q_valid, 1'b0);
        check("empty_pop_lvl", lvl(3), 9'd0);

        // Same-channel bypass on ch1 holding 3 words
        push(2'd1, 16'h0011); push(2'd1, 16'h0022); push(2'd1, 16'h0033);
        wrreq = 1'b1; wr_ch = 2'd1; data = 16'hBEEF;
        rdreq = 1'b1; rd_ch = 2'd1;
        step();
        check("byp_q", q, 16'hBEEF);
        check("byp_v", q_valid, 1'b1);
        check("byp_lvl1", lvl(1), 9'd3);
        // Push ch0 and pop ch1 together
        wr_ch = 2'd0; data = 16'h00A5;
        step();
        wrreq = 1'b0; rdreq = 1'b0;
        check("split_q", q, 16'h0033);
        check("split_ch", q_ch, 2'd1);
        check("split_lvl0", lvl(0), 9'd1);
        check("split_lvl1", lvl(1), 9'd2);
        check("split_ae1", almost_empty[1], 1'b1);

        // Fill ch0 up to 256 words
        for (int i = 2; i <= 256; i++) begin
            push(2'd0, DW'(i));
            if (i == 253) check("af_at253", almost_full[0], 1'b0);
            if (i == 254) check("af_at254", almost_full[0], 1'b1);
            if (i == 255) check("full_at255", full[0], 1'b0);
        end
        check("full_at256", full[0], 1'b1);
        push(2'd0, 16'hDEAD);
        check("overfill_lvl", lvl(0), 9'd256);
        check("overfill_full", full[0], 1'b1);
        check("others_empty", empty[3:2], 2'b11);
        check("ch1_kept", lvl(1), 9'd2);

        // Flush ch0, refill 10, then flush together with a push
        flush = 4'b0001;
        step();
        flush = '0;
        check("flush_lvl", lvl(0), 9'd0);
        for (int i = 0; i < 10; i++) push(2'd0, DW'(16'h100 + i));
        check("ch0_lvl10", lvl(0), 9'd10);
        flush = 4'b0001; wrreq = 1'b1; wr_ch = 2'd0; data = 16'h7777;
        step();
        flush = '0; wrreq = 1'b0;
        check("flushpush_lvl", lvl(0), 9'd0);
        check("flushpush_empty", empty[0], 1'b1);
        rdreq = 1'b1; rd_ch = 2'd0;
        step();
        rdreq = 1'b0;
        check("after_flush_pop_v", q_valid, 1'b0);

        // Reset right after an accepted pop
        rdreq = 1'b1; rd_ch = 2'd1;
        step();
        rdreq = 1'b0;
        check("pre_rst_q", q, 16'h0022);
        check("pre_rst_v", q_valid, 1'b1);
        srst = 1'b1;
        step();
        srst = 1'b0;
        check("srst_qvalid", q_valid, 1'b0);
        check("srst_usedw", usedw, '0);
        check("srst_empty", empty, 4'hF);
        check("srst_ae", almost_empty, 4'hF);
        check("srst_af", almost_full, 4'h0);
        check("srst_full", full, 4'h0);
        check("srst_q", q, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
